// File: rtl/cache_fill_ctrl.sv
// Fill/initialisation controller for a 128-line direct-mapped cache: sweeps all
// valid bits clear after reset, then refills 8-word blocks from memory on a miss.
module cache_fill_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  input  logic        req_hit,
  output logic        ready,
  output logic        miss_busy,
  output logic [6:0]  line_idx,
  output logic        tag_we,
  output logic        valid_wr,
  output logic        data_we,
  output logic [2:0]  word_sel,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  output logic        fill_done
);

  typedef enum logic [1:0] {INIT, IDLE, FILL, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  sweep_cnt_q, sweep_cnt_d;
  logic [2:0]  iss_cnt_q, iss_cnt_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic        iss_done_q, iss_done_d;
  logic [11:0] blk_reg_q, blk_reg_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      sweep_cnt_q <= 7'd0;
      iss_cnt_q   <= 3'd0;
      rx_cnt_q    <= 3'd0;
      iss_done_q  <= 1'b0;
      blk_reg_q   <= 12'd0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      iss_cnt_q   <= iss_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      iss_done_q  <= iss_done_d;
      blk_reg_q   <= blk_reg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    iss_cnt_d   = iss_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    iss_done_d  = iss_done_q;
    blk_reg_d   = blk_reg_q;
    ready       = 1'b0;
    miss_busy   = 1'b0;
    line_idx    = 7'd0;
    tag_we      = 1'b0;
    valid_wr    = 1'b0;
    data_we     = 1'b0;
    word_sel    = 3'd0;
    mem_req     = 1'b0;
    mem_addr    = 16'd0;
    fill_done   = 1'b0;

    case (state_q)
      INIT: begin
        miss_busy   = 1'b1;
        line_idx    = sweep_cnt_q;
        tag_we      = 1'b1;
        sweep_cnt_d = sweep_cnt_q + 7'd1;
        if (sweep_cnt_q == 7'd127) state_d = IDLE;
      end

      IDLE: begin
        ready    = 1'b1;
        line_idx = req_addr[10:4];
        if (req_valid && !req_hit) begin
          miss_busy  = 1'b1;
          blk_reg_d  = req_addr[15:4];
          iss_cnt_d  = 3'd0;
          rx_cnt_d   = 3'd0;
          iss_done_d = 1'b0;
          state_d    = FILL;
        end
      end

      // Issue and return run independently; the 3-bit issue counter wraps,
      // so iss_done is what stops a second round of requests.
      FILL: begin
        miss_busy = 1'b1;
        line_idx  = blk_reg_q[6:0];
        if (!iss_done_q) begin
          mem_req   = 1'b1;
          mem_addr  = {blk_reg_q, iss_cnt_q, 1'b0};
          iss_cnt_d = iss_cnt_q + 3'd1;
          if (iss_cnt_q == 3'd7) iss_done_d = 1'b1;
        end
        if (mem_data_valid) begin
          data_we  = 1'b1;
          word_sel = rx_cnt_q;
          rx_cnt_d = rx_cnt_q + 3'd1;
          if (rx_cnt_q == 3'd7) state_d = DONE;
        end
      end

      DONE: begin
        miss_busy = 1'b1;
        line_idx  = blk_reg_q[6:0];
        tag_we    = 1'b1;
        valid_wr  = 1'b1;
        fill_done = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = INIT;
    endcase
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Fill/initialisation controller for the 128-line direct-mapped cache arrays whose line select is produced by the 7-to-128 line decoder. It drives the 7-bit line index into that decoder and sequences tag/valid and data array writes. It clears every valid bit after reset, detects misses, and refills an 8-word block from memory through a pipelined request/return interface. It sits between the pipeline memory stage and main memory and stalls the pipeline while busy.

## Interface
- WORDS, 8, 16-bit words per block (fixed; word counters are 3 bits)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  pipeline memory access present this cycle
- req_addr  in  16  byte address; tag [15:11], index [10:4], word [3:1], bit 0 ignored
- req_hit  in  1  tag-compare result for the line currently selected by line_idx
- ready  out  1  initialisation complete and controller in IDLE
- miss_busy  out  1  pipeline stall request
- line_idx  out  7  line select into the 7-to-128 decoder
- tag_we  out  1  write enable for tag/valid array at line_idx
- valid_wr  out  1  valid-bit value written when tag_we=1
- data_we  out  1  write enable for data array at line_idx/word_sel
- word_sel  out  3  data-array word being written
- mem_req  out  1  memory read request, one word per cycle
- mem_addr  out  16  word-aligned memory read address
- mem_data_valid  in  1  one returned word this cycle, in request order
- fill_done  out  1  one-cycle pulse when a block refill commits

## Operation
- States: INIT, IDLE, FILL, DONE. Reset state INIT, sweep_cnt=0, iss_cnt=0, rx_cnt=0, blk_reg=0.
- INIT: line_idx=sweep_cnt, tag_we=1, valid_wr=0; sweep_cnt increments each cycle; at sweep_cnt=127 -> IDLE. All requests and mem_data_valid ignored; miss_busy=1, ready=0.
- IDLE: line_idx=req_addr[10:4], ready=1. If req_valid & ~req_hit: miss_busy=1 (combinational), latch blk_reg=req_addr[15:4], clear counters, -> FILL. Hit or no request: miss_busy=0, stay.
- FILL: line_idx=blk_reg[6:0]. While iss_cnt<8: mem_req=1, mem_addr={blk_reg,iss_cnt,1'b0}, iss_cnt++. Each mem_data_valid: data_we=1, word_sel=rx_cnt, rx_cnt++. When mem_data_valid with rx_cnt=7 -> DONE. Return may overlap issue, including the same cycle.
- DONE: tag_we=1, valid_wr=1, fill_done=1, line_idx=blk_reg[6:0] (tag data taken from blk_reg[11:7] by array) -> IDLE.
- miss_busy=1 in INIT, FILL, DONE; ready=1 only in IDLE.
- Outputs not listed for a state are 0. data_we is combinational on mem_data_valid in FILL only.

## Timing
- Reset: any edge with rst_n=0 forces INIT/counters 0, including mid-FILL; subsequent returning words are ignored. During and right after reset: line_idx=0, tag_we=1, valid_wr=0, all other outputs 0.
- INIT lasts exactly 128 cycles after rst_n first sampled high; ready=1 from cycle 128.
- Miss seen in cycle 0: mem_req high cycles 1-8, words 0..7 in order; no gaps.
- Memory latency L (word i valid in cycle 1+i+L): DONE in cycle 9+L, IDLE in cycle 10+L; miss_busy high cycles 0..9+L.
- req_addr/req_valid changes during FILL/DONE ignored (blk_reg latched).
- mem_data_valid in IDLE/INIT/DONE or beyond 8 words ignored; no write issued.
- Counters 3-bit; iss_cnt stops at 8 via a done flag, with no wrap re-issue.

## Test plan
- Reset release -> line_idx steps 0..127 with tag_we=1, valid_wr=0; ready rises exactly 128 cycles later.
- Miss to req_addr=16'h1A36 with L=4 memory -> mem_addr 16'h1A30,32,...,3E in cycles 1-8; data_we cycles 5-12 word_sel 0..7; line_idx=7'h23 throughout; DONE cycle 13 fill_done=1, valid_wr=1; IDLE cycle 14.
- Hit (req_hit=1) in IDLE -> miss_busy=0, no mem_req, no writes, line_idx=req_addr[10:4].
- L=0 memory (data same cycle as request) -> DONE in cycle 9; L=10 -> DONE in cycle 19; exactly 8 data_we pulses each.
- rst_n low during FILL word 3, memory keeps returning words -> INIT sweep restarts from 0, no data_we, ready after 128 cycles.
- Index 127 (req_addr=16'h07F0) miss with req_addr changing mid-fill -> all writes to line 127, mem_addr stays in block 16'h07F0-07FE.
